// File: rtl/serial_add_pkg.sv
// serial_add_pkg: FSM state encoding and default operand width shared by the serial adder
package serial_add_pkg;
    localparam int DEFAULT_WIDTH = 4;
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADD  = 2'b01,
        DONE = 2'b10
    } state_t;
endpackage

// File: rtl/full_add_1_bit.sv
// full_add_1_bit: one-bit full adder, the bit slice reused every cycle by the serial adder
module full_add_1_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/serial_add_4_bit.sv
// serial_add_4_bit: bit-serial WIDTH-bit adder, LSB first, one bit per clock
// Defining SERIAL_ADD_OVF_EN adds the registered signed-overflow output Ovf
module serial_add_4_bit
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             busy,
    output logic             done
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             Ovf
`endif
);
    localparam int CW = $clog2(WIDTH);
    state_t state, state_next;
    logic [WIDTH-1:0] a, b, sh;
    logic [WIDTH-2:0] part;
    logic [CW-1:0] cnt;
    logic c, s, c_out, last;

    full_add_1_bit u_fa (
        .a   (a[0]),
        .b   (b[0]),
        .cin (c),
        .s   (s),
        .cout(c_out)
    );

    // After the last bit this shift image is exactly the finished sum
    assign sh   = {s, part};
    assign last = cnt == CW'(WIDTH - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_next;
    end

    always_comb begin
        state_next = (state == IDLE) ? (start ? ADD : IDLE) :
                     (state == ADD)  ? (last ? DONE : ADD) : IDLE;
        busy = state != IDLE;
        done = state == DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a    <= '0;
            b    <= '0;
            c    <= 1'b0;
            part <= '0;
            cnt  <= '0;
            Sum  <= '0;
            Cout <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            Ovf  <= 1'b0;
`endif
        end else if (state == IDLE && start) begin
            a   <= X;
            b   <= Y;
            c   <= Cin;
            cnt <= '0;
        end else if (state == ADD) begin
            a    <= a >> 1;
            b    <= b >> 1;
            c    <= c_out;
            part <= sh[WIDTH-1:1];
            cnt  <= cnt + CW'(1);
            if (last) begin
                Sum  <= sh;
                Cout <= c_out;
`ifdef SERIAL_ADD_OVF_EN
                Ovf  <= c ^ c_out;
`endif
            end
        end
    end
endmodule

// File: tb/tb_serial_add_4_bit.sv
// tb_serial_add_4_bit: random and directed stimulus checked every cycle against an arithmetic model
module tb_serial_add_4_bit;
    localparam int W  = 4;
    localparam int W1 = W + 1;

    logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, Cin = 1'b0;
    logic [W-1:0] X = '0, Y = '0, Sum;
    logic Cout, busy, done;
    int checks = 0, fails = 0;

    always #5 clk = ~clk;

`ifdef SERIAL_ADD_OVF_EN
    logic Ovf;
`endif

    serial_add_4_bit #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .X    (X),
        .Y    (Y),
        .Cin  (Cin),
        .Sum  (Sum),
        .Cout (Cout),
        .busy (busy),
        .done (done)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .Ovf  (Ovf)
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Model: phase 0 idle, 1..W adding, W+1 done; results from plain integer arithmetic
    int phase = 0;
    logic [W:0] pend;
    logic [W-1:0] m_sum = '0;
    logic m_cout = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
    logic pend_ovf, m_ovf = 1'b0;

    function automatic logic sovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        int sx, sy, t;
        sx = int'(x) - (x[W-1] ? (1 << W) : 0);
        sy = int'(y) - (y[W-1] ? (1 << W) : 0);
        t = sx + sy + int'(ci);
        return t > (1 << (W - 1)) - 1 || t < -(1 << (W - 1));
    endfunction
`endif

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase  <= 0;
            m_sum  <= '0;
            m_cout <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            m_ovf  <= 1'b0;
`endif
        end else if (phase == 0) begin
            if (start) begin
                phase <= 1;
                pend  <= W1'(X) + W1'(Y) + W1'(Cin);
`ifdef SERIAL_ADD_OVF_EN
                pend_ovf <= sovf(X, Y, Cin);
`endif
            end
        end else if (phase == W) begin
            phase  <= W + 1;
            m_sum  <= pend[W-1:0];
            m_cout <= pend[W];
`ifdef SERIAL_ADD_OVF_EN
            m_ovf  <= pend_ovf;
`endif
        end else if (phase == W + 1) begin
            phase <= 0;
        end else begin
            phase <= phase + 1;
        end
    end

    always @(negedge clk) begin
        chk("busy", int'(busy), int'(phase != 0));
        chk("done", int'(done), int'(phase == W + 1));
        chk("sum", int'(Sum), int'(m_sum));
        chk("cout", int'(Cout), int'(m_cout));
`ifdef SERIAL_ADD_OVF_EN
        chk("ovf", int'(Ovf), int'(m_ovf));
`endif
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", int'(busy), 0);
    endtask

    task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                      output int lat, output int bcnt);
        wait_idle();
        #1;
        X = x;
        Y = y;
        Cin = ci;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        bcnt = 0;
        while (lat < 40) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done) break;
            @(posedge clk);
            lat++;
        end
        if (!done) chk("done_timeout", int'(done), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, bc, last_done, ndone;
        logic [W-1:0] rx, ry;
        logic rc;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_sum", int'(Sum), 0);
        chk("rst_cout", int'(Cout), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;

        op(4'd5, 4'd3, 1'b0, lat, bc);
        chk("lat_5p3", lat, 4);
        chk("busy_len_5p3", bc, 5);
        chk("sum_5p3", int'(Sum), 8);
        chk("cout_5p3", int'(Cout), 0);
        chk("model_sum_5p3", int'(m_sum), 8);

        op(4'hF, 4'd1, 1'b0, lat, bc);
        chk("sum_f_1", int'(Sum), 0);
        chk("cout_f_1", int'(Cout), 1);
        chk("model_cout_f_1", int'(m_cout), 1);
        op(4'hF, 4'hF, 1'b1, lat, bc);
        chk("sum_f_f_1", int'(Sum), 15);
        chk("cout_f_f_1", int'(Cout), 1);

        // start held high; operands scrambled whenever an add is in flight
        wait_idle();
        #1;
        X = 4'd2;
        Y = 4'd2;
        Cin = 1'b0;
        start = 1'b1;
        last_done = -1;
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) begin
                chk("hold_sum", int'(Sum), 4);
                if (last_done >= 0) chk("hold_period", i - last_done, 6);
                last_done = i;
                ndone++;
            end
            #1;
            if (busy) begin
                X = W'($urandom);
                Y = W'($urandom);
            end else begin
                X = 4'd2;
                Y = 4'd2;
            end
        end
        start = 1'b0;
        chk("hold_count", ndone, 5);

        // reset in the second ADD cycle aborts the add
        wait_idle();
        #1;
        X = 4'd9;
        Y = 4'd3;
        Cin = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_sum", int'(Sum), 0);
        chk("abort_cout", int'(Cout), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", int'(done), 0);
        end
        #1 rst_n = 1'b1;
        op(4'd1, 4'd1, 1'b0, lat, bc);
        chk("post_rst_lat", lat, 4);
        chk("post_rst_sum", int'(Sum), 2);

`ifdef SERIAL_ADD_OVF_EN
        op(4'd7, 4'd1, 1'b0, lat, bc);
        chk("ovf_7_1_sum", int'(Sum), 8);
        chk("ovf_7_1_ovf", int'(Ovf), 1);
        chk("ovf_7_1_cout", int'(Cout), 0);
        op(4'd8, 4'd8, 1'b0, lat, bc);
        chk("ovf_8_8_sum", int'(Sum), 0);
        chk("ovf_8_8_cout", int'(Cout), 1);
        chk("ovf_8_8_ovf", int'(Ovf), 1);
        op(4'd3, 4'd2, 1'b0, lat, bc);
        chk("ovf_3_2_ovf", int'(Ovf), 0);
`endif

        for (int i = 0; i < 20; i++) begin
            rx = W'($urandom);
            ry = W'($urandom);
            rc = 1'($urandom);
            op(rx, ry, rc, lat, bc);
            chk("rand_lat", lat, W);
            chk("rand_sum", int'(Sum), (int'(rx) + int'(ry) + int'(rc)) % (1 << W));
            chk("rand_cout", int'(Cout), (int'(rx) + int'(ry) + int'(rc)) >> W);
        end

        // free-running random start/operand traffic, including starts while busy
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #1;
            start = $urandom_range(0, 2) == 0;
            X = W'($urandom);
            Y = W'($urandom);
            Cin = 1'($urandom);
        end
        start = 1'b0;
        repeat (W + 4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
